// File: rtl/matmul_host_link.sv
// rtl/matmul_host_link.sv - host-side operand buffer, load sequencer and result capture
// for the matrix-multiply datapath.
module matmul_host_link #(
   parameter int N_IN      = 12,
   parameter int IN_W      = 8,
   parameter int N_OUT     = 9,
   parameter int OUT_W     = 16,
   parameter int OUT_DELAY = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [3:0]       wr_addr,
   input  logic [IN_W-1:0]  wr_data,
   input  logic             start,
   input  logic [3:0]       rd_addr,
   output logic [OUT_W-1:0] rd_data,
   output logic             cf_load,
   output logic [IN_W-1:0]  din,
   output logic             din_vld,
   input  logic [OUT_W-1:0] dout,
   output logic             busy,
   output logic             done,
   output logic             wr_err
);

   typedef enum logic [2:0] {IDLE, REQ, STREAM, WAIT, CAPT, DONE} state_t;

   localparam logic [3:0] N_IN_L    = 4'(N_IN);
   localparam logic [3:0] N_OUT_L   = 4'(N_OUT);
   localparam logic [3:0] IN_LAST   = 4'(N_IN - 1);
   localparam logic [3:0] OUT_LAST  = 4'(N_OUT - 1);
   localparam logic [5:0] WAIT_LAST = (OUT_DELAY == 0) ? 6'd0 : 6'(OUT_DELAY - 1);

   state_t           state;
   logic [3:0]       k_cnt;
   logic [3:0]       j_cnt;
   logic [5:0]       w_cnt;
   logic [IN_W-1:0]  op  [N_IN];
   logic [OUT_W-1:0] res [N_OUT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cf_load <= 1'b0;
         din     <= '0;
         din_vld <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_err  <= 1'b0;
         k_cnt   <= '0;
         j_cnt   <= '0;
         w_cnt   <= '0;
         for (int i = 0; i < N_IN; i++) op[i] <= '0;
         for (int i = 0; i < N_OUT; i++) res[i] <= '0;
      end else begin
         // Writes are only accepted in IDLE and only to a valid operand slot.
         wr_err <= wr_en && (state != IDLE || wr_addr >= N_IN_L);
         case (state)
            IDLE: begin
               if (wr_en && wr_addr < N_IN_L) op[wr_addr] <= wr_data;
               if (start) begin
                  state   <= REQ;
                  cf_load <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            REQ: begin
               cf_load <= 1'b0;
               din     <= op[0];
               din_vld <= 1'b1;
               k_cnt   <= '0;
               state   <= STREAM;
            end
            STREAM: begin
               if (k_cnt == IN_LAST) begin
                  din     <= '0;
                  din_vld <= 1'b0;
                  w_cnt   <= '0;
                  j_cnt   <= '0;
                  state   <= (OUT_DELAY == 0) ? CAPT : WAIT;
               end else begin
                  k_cnt <= k_cnt + 4'd1;
                  din   <= op[k_cnt + 4'd1];
               end
            end
            WAIT: begin
               if (w_cnt == WAIT_LAST) begin
                  j_cnt <= '0;
                  state <= CAPT;
               end else begin
                  w_cnt <= w_cnt + 6'd1;
               end
            end
            CAPT: begin
               res[j_cnt] <= dout;
               if (j_cnt == OUT_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  j_cnt <= j_cnt + 4'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_addr < N_OUT_L) rd_data = res[rd_addr];
   end

endmodule

// File: tb/tb_matmul_host_link.sv
// tb/tb_matmul_host_link.sv - randomized self-checking bench for matmul_host_link,
// default build plus an OUT_DELAY=0 build driven in parallel.
module tb_matmul_host_link;

   localparam int D  = 14;
   localparam int D0 = 0;

   logic        clk = 1'b0;
   logic        reset, wr_en, start;
   logic [3:0]  wr_addr, rd_addr;
   logic [7:0]  wr_data;
   logic [15:0] dout, dout0;
   logic [15:0] rd_data, rd_data0;
   logic [7:0]  din, din0;
   logic        cf_load, cf_load0, din_vld, din_vld0;
   logic        busy, busy0, done, done0, wr_err, wr_err0;

   matmul_host_link #(.OUT_DELAY(D)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .cf_load(cf_load),
      .din(din), .din_vld(din_vld), .dout(dout), .busy(busy), .done(done), .wr_err(wr_err));

   matmul_host_link #(.OUT_DELAY(D0)) dut0 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .rd_addr(rd_addr), .rd_data(rd_data0), .cf_load(cf_load0),
      .din(din0), .din_vld(din_vld0), .dout(dout0), .busy(busy0), .done(done0), .wr_err(wr_err0));

   always #5 clk = ~clk;

   int          passed = 0;
   int          total  = 0;
   logic [7:0]  op_m [12];
   logic [15:0] pat  [9];
   logic [11:0] o_vec  [41];
   logic [11:0] o0_vec [41];
   logic        o_err  [41];
   logic        o0_err [41];

   // Expected {cf_load, din_vld, busy, done, din} in cycle c of a job started at edge 0.
   function automatic logic [11:0] exp_vec(input int c, input int d);
      logic       vld;
      logic [7:0] dv;
      vld = (c >= 2 && c <= 13);
      dv  = vld ? op_m[c-2] : 8'h00;
      return {(c == 1), vld, (c >= 1 && c <= 13 + d + 9), (c == 14 + d + 9), dv};
   endfunction

   task automatic write_op(input logic [3:0] a, input logic [7:0] d, output logic err);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      err = wr_err;
      wr_en = 1'b0;
      if (a < 4'd12) op_m[a] = d;
   endtask

   task automatic randomize_pat();
      for (int j = 0; j < 9; j++) pat[j] = 16'($urandom_range(0, 16'hFFFE));
   endtask

   // Runs one job from the next falling edge; records outputs of both builds per cycle.
   task automatic run_job(input int wr_cyc, input logic [3:0] wa, input logic [7:0] wd,
                          input int st_cyc);
      @(negedge clk);
      start = 1'b1; dout = 16'hFFFF; dout0 = 16'hFFFF;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         o_vec[c]  = {cf_load, din_vld, busy, done, din};
         o0_vec[c] = {cf_load0, din_vld0, busy0, done0, din0};
         o_err[c]  = wr_err;
         o0_err[c] = wr_err0;
         start   = (c == st_cyc);
         wr_en   = (c == wr_cyc);
         wr_addr = wa;
         wr_data = wd;
         dout  = (c >= 14 + D  && c < 14 + D  + 9) ? pat[c-14-D]  : 16'hFFFF;
         dout0 = (c >= 14 + D0 && c < 14 + D0 + 9) ? pat[c-14-D0] : 16'hFFFF;
      end
      start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({cf_load, din_vld, busy, done, wr_err, din} !== 13'd0)
         $display("FAIL reset_outputs got %h exp 0", {cf_load, din_vld, busy, done, wr_err, din});
      else passed++;
      reset = 1'b0;
      @(negedge clk);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); #1;
         total++;
         if (rd_data !== 16'h0) $display("FAIL reset_rd addr %0d got %h exp 0", a, rd_data);
         else passed++;
      end
      for (int i = 0; i < 12; i++) op_m[i] = 8'h00;
   endtask

   task automatic test_basic();
      logic err;
      for (int i = 0; i < 12; i++) begin
         write_op(4'(i), 8'(i + 1), err);
         total++;
         if (err !== 1'b0) $display("FAIL basic_wr_err addr %0d got %b exp 0", i, err);
         else passed++;
      end
      for (int j = 0; j < 9; j++) pat[j] = 16'h0100 + 16'(j);
      run_job(-1, 4'd0, 8'd0, -1);
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o_vec[c] !== exp_vec(c, D))
            $display("FAIL basic_timeline cycle %0d got %h exp %h", c, o_vec[c], exp_vec(c, D));
         else passed++;
      end
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); #1;
         total++;
         if (rd_data !== ((a < 9) ? 16'h0100 + 16'(a) : 16'h0))
            $display("FAIL basic_rd addr %0d got %h exp %h", a, rd_data,
                     (a < 9) ? 16'h0100 + 16'(a) : 16'h0);
         else passed++;
      end
   endtask

   task automatic test_delay0();
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o0_vec[c] !== exp_vec(c, D0))
            $display("FAIL delay0_timeline cycle %0d got %h exp %h", c, o0_vec[c], exp_vec(c, D0));
         else passed++;
      end
      for (int a = 0; a < 9; a++) begin
         rd_addr = 4'(a); #1;
         total++;
         if (rd_data0 !== pat[a]) $display("FAIL delay0_rd addr %0d got %h exp %h", a, rd_data0, pat[a]);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic err;
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 12; i++) write_op(4'(i), 8'($urandom), err);
         randomize_pat();
         run_job(-1, 4'd0, 8'd0, -1);
         for (int c = 1; c <= 40; c++) begin
            total++;
            if (o_vec[c] !== exp_vec(c, D))
               $display("FAIL random_timeline job %0d cycle %0d got %h exp %h", n, c, o_vec[c], exp_vec(c, D));
            else passed++;
         end
         for (int a = 0; a < 9; a++) begin
            rd_addr = 4'(a); #1;
            total++;
            if (rd_data !== pat[a]) $display("FAIL random_rd job %0d addr %0d got %h exp %h", n, a, rd_data, pat[a]);
            else passed++;
         end
      end
   endtask

   task automatic test_bad_addr();
      logic err;
      write_op(4'd12, 8'h55, err);
      total++;
      if (err !== 1'b1) $display("FAIL bad_addr_err12 got %b exp 1", err);
      else passed++;
      write_op(4'($urandom_range(13, 15)), 8'($urandom), err);
      total++;
      if (err !== 1'b1) $display("FAIL bad_addr_err_hi got %b exp 1", err);
      else passed++;
      @(negedge clk);
      total++;
      if (wr_err !== 1'b0) $display("FAIL bad_addr_pulse_width got %b exp 0", wr_err);
      else passed++;
      randomize_pat();
      run_job(-1, 4'd0, 8'd0, -1);
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o_vec[c] !== exp_vec(c, D))
            $display("FAIL bad_addr_timeline cycle %0d got %h exp %h", c, o_vec[c], exp_vec(c, D));
         else passed++;
      end
   endtask

   task automatic test_busy_reject();
      randomize_pat();
      run_job(5, 4'd3, 8'hAA, 20);
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o_vec[c] !== exp_vec(c, D) || o_err[c] !== (c == 6))
            $display("FAIL busy_reject cycle %0d got %h/%b exp %h/%b", c, o_vec[c], o_err[c],
                     exp_vec(c, D), (c == 6));
         else passed++;
      end
      run_job(-1, 4'd0, 8'd0, -1);
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o_vec[c] !== exp_vec(c, D))
            $display("FAIL busy_reject_next cycle %0d got %h exp %h", c, o_vec[c], exp_vec(c, D));
         else passed++;
      end
   endtask

   task automatic test_midjob_reset();
      rd_addr = 4'd0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      total++;
      if (busy !== 1'b1 || din_vld !== 1'b1) $display("FAIL midreset_pre got %b%b exp 11", busy, din_vld);
      else passed++;
      reset = 1'b1; #1;
      total++;
      if ({cf_load, din_vld, busy, done, wr_err, din, rd_data} !== 29'd0)
         $display("FAIL midreset_outputs got %h exp 0", {cf_load, din_vld, busy, done, wr_err, din, rd_data});
      else passed++;
      total++;
      if ({cf_load0, din_vld0, busy0, done0, wr_err0, din0, rd_data0} !== 29'd0)
         $display("FAIL midreset_outputs0 got %h exp 0", {cf_load0, din_vld0, busy0, done0, wr_err0, din0, rd_data0});
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) op_m[i] = 8'h00;
      randomize_pat();
      run_job(-1, 4'd0, 8'd0, -1);
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o_vec[c] !== exp_vec(c, D))
            $display("FAIL midreset_job cycle %0d got %h exp %h", c, o_vec[c], exp_vec(c, D));
         else passed++;
      end
      for (int a = 0; a < 9; a++) begin
         rd_addr = 4'(a); #1;
         total++;
         if (rd_data !== pat[a]) $display("FAIL midreset_rd addr %0d got %h exp %h", a, rd_data, pat[a]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic err;
      for (int i = 0; i < 12; i++) write_op(4'(i), 8'($urandom), err);
      randomize_pat();
      run_job(-1, 4'd0, 8'd0, 37);
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o_vec[c] !== exp_vec(c, D))
            $display("FAIL b2b_done_start cycle %0d got %h exp %h", c, o_vec[c], exp_vec(c, D));
         else passed++;
      end
      randomize_pat();
      run_job(-1, 4'd0, 8'd0, -1);
      for (int c = 1; c <= 40; c++) begin
         total++;
         if (o_vec[c] !== exp_vec(c, D))
            $display("FAIL b2b_next_job cycle %0d got %h exp %h", c, o_vec[c], exp_vec(c, D));
         else passed++;
      end
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; dout = 16'hFFFF; dout0 = 16'hFFFF;
      test_reset();
      test_basic();
      test_delay0();
      test_random();
      test_bad_addr();
      test_busy_reject();
      test_midjob_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
